// File: rtl/pipe_rca4.sv
// pipe_rca4: 4-bit ripple-carry adder, bit-level pipelined.
// One full-adder bit per rank (R0..R3); each carry is registered and travels
// with its own operand set. Operand bits not yet consumed ride forward in skew
// registers, and finished sum bits ride forward in deskew registers.
// Result {Cout, Sum} = A + B + Cin appears 3 edges after the operands are sampled.
module pipe_rca4 (
  output logic       Cout,
  output logic [3:0] Sum,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       Clk,
  input  logic       Rst
);

  // Single-bit full adder; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Rank 0: sum bit 0, carry out of bit 0, operand bits 3..1 skewed forward.
  logic       r0_sum_q, r0_sum_d;
  logic       r0_c_q,   r0_c_d;
  logic [3:1] r0_a_q,   r0_a_d;
  logic [3:1] r0_b_q,   r0_b_d;

  // Rank 1: sum bits 1..0, carry out of bit 1, operand bits 3..2.
  logic [1:0] r1_sum_q, r1_sum_d;
  logic       r1_c_q,   r1_c_d;
  logic [3:2] r1_a_q,   r1_a_d;
  logic [3:2] r1_b_q,   r1_b_d;

  // Rank 2: sum bits 2..0, carry out of bit 2, operand bit 3.
  logic [2:0] r2_sum_q, r2_sum_d;
  logic       r2_c_q,   r2_c_d;
  logic       r2_a_q,   r2_a_d;
  logic       r2_b_q,   r2_b_d;

  // Rank 3: complete sum and final carry; drives the outputs directly.
  logic [3:0] r3_sum_q, r3_sum_d;
  logic       r3_c_q,   r3_c_d;

  // Next-state: one full adder per rank, plus skew/deskew copies.
  // NOTE: combinational logic uses blocking (=); every register below uses
  // non-blocking (<=) so all ranks see the pre-edge values of their neighbours.
  always_comb begin
    // R0 takes bit 0 straight from the ports.
    {r0_c_d, r0_sum_d} = full_add(A[0], B[0], Cin);
    r0_a_d             = A[3:1];
    r0_b_d             = B[3:1];

    // R1 consumes skewed bit 1 and the carry registered in R0.
    {r1_c_d, r1_sum_d[1]} = full_add(r0_a_q[1], r0_b_q[1], r0_c_q);
    r1_sum_d[0]           = r0_sum_q;
    r1_a_d                = r0_a_q[3:2];
    r1_b_d                = r0_b_q[3:2];

    // R2 consumes skewed bit 2 and the carry registered in R1.
    {r2_c_d, r2_sum_d[2]} = full_add(r1_a_q[2], r1_b_q[2], r1_c_q);
    r2_sum_d[1:0]         = r1_sum_q;
    r2_a_d                = r1_a_q[3];
    r2_b_d                = r1_b_q[3];

    // R3 consumes skewed bit 3 and the carry registered in R2.
    {r3_c_d, r3_sum_d[3]} = full_add(r2_a_q, r2_b_q, r2_c_q);
    r3_sum_d[2:0]         = r2_sum_q;
  end

  // Pipeline registers with synchronous reset taking priority over loading.
  // NOTE: skew registers are cleared along with sums and carries; the zeros
  // flushed into the pipe must add to zero so outputs read 0 until new data lands.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r0_sum_q <= 1'b0;
      r0_c_q   <= 1'b0;
      r0_a_q   <= '0;
      r0_b_q   <= '0;
      r1_sum_q <= '0;
      r1_c_q   <= 1'b0;
      r1_a_q   <= '0;
      r1_b_q   <= '0;
      r2_sum_q <= '0;
      r2_c_q   <= 1'b0;
      r2_a_q   <= 1'b0;
      r2_b_q   <= 1'b0;
      r3_sum_q <= '0;
      r3_c_q   <= 1'b0;
    end else begin
      r0_sum_q <= r0_sum_d;
      r0_c_q   <= r0_c_d;
      r0_a_q   <= r0_a_d;
      r0_b_q   <= r0_b_d;
      r1_sum_q <= r1_sum_d;
      r1_c_q   <= r1_c_d;
      r1_a_q   <= r1_a_d;
      r1_b_q   <= r1_b_d;
      r2_sum_q <= r2_sum_d;
      r2_c_q   <= r2_c_d;
      r2_a_q   <= r2_a_d;
      r2_b_q   <= r2_b_d;
      r3_sum_q <= r3_sum_d;
      r3_c_q   <= r3_c_d;
    end
  end

  // Outputs come only from R3, so there is no input-to-output combinational path.
  assign Sum  = r3_sum_q;
  assign Cout = r3_c_q;

endmodule

// File: tb/tb_pipe_rca4.sv
// Testbench for pipe_rca4: table-driven vectors feeding a scoreboard queue.
// Each driven operand set pushes its expected {Cout, Sum}; each clock pops the
// value due at the output (3 edges after sampling) and compares.
module tb_pipe_rca4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] A   = '0;
  logic [3:0] B   = '0;
  logic       Cin = 1'b0;
  logic       Cout;
  logic [3:0] Sum;

  pipe_rca4 dut (
    .Cout (Cout),
    .Sum  (Sum),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Clk  (Clk),
    .Rst  (Rst)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] sb[$];

  task automatic check(input string name, input logic [4:0] actual, input logic [4:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got {Cout,Sum}=%b_%0d, expected %b_%0d",
               name, actual[4], actual[3:0], expected[4], expected[3:0]);
    end
  endtask

  // Drive one set at the falling edge, clock it in, then compare the output
  // due at this edge. On a reset edge the output must be 0 and the scoreboard
  // restarts with the three zero results flushed into the pipe. With toggle set,
  // inputs are scrambled between edges and the output must not move.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic rst, input logic [4:0] result, input bit toggle,
                      input string tag);
    logic [4:0] exp;
    @(negedge Clk);
    A   = a;
    B   = b;
    Cin = cin;
    Rst = rst;
    @(posedge Clk);
    #1;
    if (rst) begin
      sb.delete();
      repeat (3) sb.push_back(5'd0);
      exp = 5'd0;
    end else begin
      sb.push_back(result);
      exp = sb.pop_front();
    end
    check(tag, {Cout, Sum}, exp);
    if (toggle) begin
      A   = 4'($urandom);
      B   = 4'($urandom);
      Cin = 1'($urandom);
      #2;
      check({tag, "_hold"}, {Cout, Sum}, exp);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(4'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0, tag);
  endtask

  vec_t stream_tbl[5];
  vec_t carry_tbl[4];

  initial begin
    stream_tbl[0] = '{4'd7, 4'd5, 1'b0, 4'd12, 1'b0};
    stream_tbl[1] = '{4'd1, 4'd2, 1'b0, 4'd3,  1'b0};
    stream_tbl[2] = '{4'd3, 4'd2, 1'b0, 4'd5,  1'b0};
    stream_tbl[3] = '{4'd5, 4'd2, 1'b1, 4'd8,  1'b0};
    stream_tbl[4] = '{4'd1, 4'd1, 1'b0, 4'd2,  1'b0};

    carry_tbl[0]  = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
    carry_tbl[1]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    carry_tbl[2]  = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
    carry_tbl[3]  = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};

    // Reset for two cycles; outputs must read 0.
    step(4'd9, 4'd9, 1'b1, 1'b1, 5'd0, 1'b0, "reset0");
    step(4'd9, 4'd9, 1'b1, 1'b1, 5'd0, 1'b0, "reset1");

    // Single add: zeros for two cycles, then 12.
    step(4'd7, 4'd5, 1'b0, 1'b0, 5'd12, 1'b0, "single");
    idle(4, "single_tail");

    // Back-to-back stream.
    foreach (stream_tbl[i])
      step(stream_tbl[i].a, stream_tbl[i].b, stream_tbl[i].cin, 1'b0,
           {stream_tbl[i].exp_cout, stream_tbl[i].exp_sum}, 1'b0, $sformatf("stream%0d", i));
    idle(3, "stream_tail");

    // Carry chains back to back.
    foreach (carry_tbl[i])
      step(carry_tbl[i].a, carry_tbl[i].b, carry_tbl[i].cin, 1'b0,
           {carry_tbl[i].exp_cout, carry_tbl[i].exp_sum}, 1'b0, $sformatf("carry%0d", i));
    idle(3, "carry_tail");

    // Reset mid-stream: both in-flight results are flushed; inputs on the
    // reset edge are discarded; (2,3,0) emerges 3 edges after it is sampled.
    step(4'd15, 4'd15, 1'b1, 1'b0, 5'd31, 1'b0, "mid_a");
    step(4'd7,  4'd7,  1'b0, 1'b0, 5'd14, 1'b0, "mid_b");
    step(4'd9,  4'd6,  1'b1, 1'b1, 5'd0,  1'b0, "mid_reset");
    step(4'd2,  4'd3,  1'b0, 1'b0, 5'd5,  1'b0, "mid_after");
    idle(4, "mid_tail");

    // Exhaustive: all 512 combinations, with inputs scrambled between edges.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] ref_res;
      v       = 9'(i);
      ref_res = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      step(v[3:0], v[7:4], v[8], 1'b0, ref_res, 1'b1, $sformatf("exh%0d", i));
    end
    idle(3, "exh_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
